// File: rtl/instr_fetch.sv
// ============================================================================
// instr_fetch
// ----------------------------------------------------------------------------
// Instruction fetch unit. Owns the program counter, drives the instruction ROM
// address, and registers the combinationally returned instruction. Fetched
// instructions go to decode over a valid/ready handshake. Execute may redirect
// the PC at any time with a one-cycle pulse.
//
// Optional feature macro: IFETCH_BOUND_CHK_EN
//   defined   : fetches at PC >= TOTAL_ROM_SIZE raise o_fault and park the
//               unit in FAULT until a redirect or reset.
//   undefined : no bounds check; o_fault is tied 0.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   o_rom_addr   ROM word address (current PC)
//   i_rom_instr  ROM data, valid in the same cycle as o_rom_addr
//   o_instr      registered fetched instruction
//   o_pc         address o_instr was fetched from
//   o_valid      o_instr/o_pc hold a live instruction
//   i_ready      decode accepts o_instr this cycle
//   i_redirect   one-cycle pulse: drop in-flight fetch, continue at i_target
//   i_target     redirect address
//   o_fault      out-of-range fetch attempted (bounds-check build only)
// ============================================================================
module instr_fetch #(
    parameter int unsigned             CONTENT_SIZE   = 16,
    parameter int unsigned             INSTRUCT_SIZE  = 32,
    parameter int unsigned             TOTAL_ROM_SIZE = 256,
    parameter logic [CONTENT_SIZE-1:0] RESET_PC       = '0
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    output logic [CONTENT_SIZE-1:0]  o_rom_addr,
    input  logic [INSTRUCT_SIZE-1:0] i_rom_instr,
    output logic [INSTRUCT_SIZE-1:0] o_instr,
    output logic [CONTENT_SIZE-1:0]  o_pc,
    output logic                     o_valid,
    input  logic                     i_ready,
    input  logic                     i_redirect,
    input  logic [CONTENT_SIZE-1:0]  i_target,
    output logic                     o_fault
);

    logic [CONTENT_SIZE-1:0]  pc_q,     pc_d;
    logic [INSTRUCT_SIZE-1:0] instr_q,  instr_d;
    logic [CONTENT_SIZE-1:0]  out_pc_q, out_pc_d;
    logic                     valid_q,  valid_d;
    logic                     advance;

`ifdef IFETCH_BOUND_CHK_EN
    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_e;

    // One extra bit so a ROM size of 2^CONTENT_SIZE is still representable.
    localparam logic [CONTENT_SIZE:0] ROM_LIMIT = (CONTENT_SIZE + 1)'(TOTAL_ROM_SIZE);

    state_e state_q, state_d;
    logic   fault_q, fault_d;
    logic   out_of_range;

    assign out_of_range = {1'b0, pc_q} >= ROM_LIMIT;
`endif

    // Output register is free when empty or being drained this cycle.
    assign advance = !valid_q || i_ready;

    always_comb begin
        // NOTE: every signal gets a hold value first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        pc_d     = pc_q;
        instr_d  = instr_q;
        out_pc_d = out_pc_q;
        valid_d  = valid_q;
`ifdef IFETCH_BOUND_CHK_EN
        state_d  = state_q;
        fault_d  = fault_q;
`endif

        if (i_redirect) begin
            // Redirect wins over everything. Whatever is presented is either
            // consumed this cycle by decode or dropped; no capture happens.
            pc_d    = i_target;
            valid_d = 1'b0;
`ifdef IFETCH_BOUND_CHK_EN
            fault_d = 1'b0;
            state_d = RUN;
`endif
        end
`ifdef IFETCH_BOUND_CHK_EN
        else if (state_q == RUN && advance) begin
            if (out_of_range) begin
                valid_d = 1'b0;
                fault_d = 1'b1;
                state_d = FAULT;
            end else begin
                instr_d  = i_rom_instr;
                out_pc_d = pc_q;
                valid_d  = 1'b1;
                pc_d     = pc_q + CONTENT_SIZE'(1);
            end
        end
        // FAULT: hold everything until a redirect arrives.
`else
        else if (advance) begin
            instr_d  = i_rom_instr;
            out_pc_d = pc_q;
            valid_d  = 1'b1;
            pc_d     = pc_q + CONTENT_SIZE'(1);
        end
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_q     <= RESET_PC;
            instr_q  <= '0;
            out_pc_q <= '0;
            valid_q  <= 1'b0;
`ifdef IFETCH_BOUND_CHK_EN
            state_q  <= RUN;
            fault_q  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values, independent of statement order.
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            out_pc_q <= out_pc_d;
            valid_q  <= valid_d;
`ifdef IFETCH_BOUND_CHK_EN
            state_q  <= state_d;
            fault_q  <= fault_d;
`endif
        end
    end

    assign o_rom_addr = pc_q;
    assign o_instr    = instr_q;
    assign o_pc       = out_pc_q;
    assign o_valid    = valid_q;
`ifdef IFETCH_BOUND_CHK_EN
    assign o_fault    = fault_q;
`else
    assign o_fault    = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// ============================================================================
// tb_instr_fetch
// ----------------------------------------------------------------------------
// Directed bench for instr_fetch with a scoreboard. The stimulus script pushes
// each (pc, instr) pair it expects decode to accept; a monitor pops and
// compares on every accepted handshake (o_valid && i_ready at the falling
// edge). Point checks cover reset, stall stability, redirect bubbles and the
// asynchronous reset.
// ============================================================================
module tb_instr_fetch;

    localparam logic [31:0] W0 = 32'h0801_0000;
    localparam logic [31:0] W1 = 32'h0822_0001;
    localparam logic [31:0] W2 = 32'h0440_0800;

    typedef struct {
        logic [15:0] pc;
        logic [31:0] instr;
    } xfer_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] rom_addr;
    logic [31:0] rom_data;
    logic [31:0] instr;
    logic [15:0] pc;
    logic        valid;
    logic        ready;
    logic        redirect;
    logic [15:0] target;
    logic        fault;

    logic [31:0] rom [0:255];
    xfer_t       exp_q [$];
    int          tests_run;
    int          tests_failed;

    instr_fetch dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .o_rom_addr  (rom_addr),
        .i_rom_instr (rom_data),
        .o_instr     (instr),
        .o_pc        (pc),
        .o_valid     (valid),
        .i_ready     (ready),
        .i_redirect  (redirect),
        .i_target    (target),
        .o_fault     (fault)
    );

    // Combinational ROM; unpopulated addresses return a recognisable pattern.
    assign rom_data = (rom_addr < 16'd256) ? rom[rom_addr[7:0]]
                                           : (32'hDEAD_0000 | {16'h0000, rom_addr});

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic expect_xfer(input logic [15:0] p, input logic [31:0] w);
        xfer_t x;
        x.pc    = p;
        x.instr = w;
        exp_q.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: one pop per accepted instruction.
    always @(negedge clk) begin
        if (rst_n && valid && ready) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL unexpected_xfer: got pc %h instr %h, expected none", pc, instr);
            end else begin
                xfer_t x;
                x = exp_q.pop_front();
                check("xfer_pc", {16'h0000, pc}, {16'h0000, x.pc});
                check("xfer_instr", instr, x.instr);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        for (int i = 0; i < 256; i++) rom[i] = 32'hA5A5_0000 | i;
        rom[0] = W0;
        rom[1] = W1;
        rom[2] = W2;

        rst_n    = 1'b0;
        ready    = 1'b0;
        redirect = 1'b0;
        target   = 16'h0000;
        #12;
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_pc", {16'h0000, pc}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_rom_addr", {16'h0000, rom_addr}, 32'd0);

        // Back-to-back fetch of words 0..2.
        expect_xfer(16'h0000, W0);
        expect_xfer(16'h0001, W1);
        expect_xfer(16'h0002, W2);
        ready = 1'b1;
        rst_n = 1'b1;
        step();
        check("first_valid", {31'd0, valid}, 32'd1);
        check("first_pc", {16'h0000, pc}, 32'd0);
        step();
        step();

        // Redirect while word 2 is being accepted: counted once, then a bubble.
        redirect = 1'b1;
        target   = 16'h0040;
        step();
        redirect = 1'b0;
        ready    = 1'b0;
        check("redir_bubble", {31'd0, valid}, 32'd0);
        step();
        check("redir_valid", {31'd0, valid}, 32'd1);
        check("redir_pc", {16'h0000, pc}, 32'h0040);
        check("redir_instr", instr, 32'hA5A5_0040);

        // Redirect with ready low: 0x40 is dropped, never accepted.
        redirect = 1'b1;
        target   = 16'h0001;
        step();
        redirect = 1'b0;
        check("drop_bubble", {31'd0, valid}, 32'd0);
        step();
        check("stall_start_pc", {16'h0000, pc}, 32'd1);
        check("stall_start_addr", {16'h0000, rom_addr}, 32'd2);

        // Four stalled cycles: everything stable.
        for (int i = 0; i < 4; i++) begin
            step();
            check("stall_valid", {31'd0, valid}, 32'd1);
            check("stall_pc", {16'h0000, pc}, 32'd1);
            check("stall_instr", instr, W1);
            check("stall_addr", {16'h0000, rom_addr}, 32'd2);
        end
        expect_xfer(16'h0001, W1);
        ready = 1'b1;
        step();
        check("after_stall_pc", {16'h0000, pc}, 32'd2);
        ready = 1'b0;

`ifdef IFETCH_BOUND_CHK_EN
        // Last two populated words, then a fault, then recovery by redirect.
        redirect = 1'b1;
        target   = 16'h00FE;
        step();
        redirect = 1'b0;
        step();
        check("bound_pc_fe", {16'h0000, pc}, 32'h00FE);
        expect_xfer(16'h00FE, 32'hA5A5_00FE);
        expect_xfer(16'h00FF, 32'hA5A5_00FF);
        ready = 1'b1;
        step();
        step();
        check("fault_set", {31'd0, fault}, 32'd1);
        check("fault_valid", {31'd0, valid}, 32'd0);
        redirect = 1'b1;
        target   = 16'h0000;
        step();
        redirect = 1'b0;
        check("fault_clear", {31'd0, fault}, 32'd0);
        expect_xfer(16'h0000, W0);
        step();
        check("recover_pc", {16'h0000, pc}, 32'd0);
        step();
        ready = 1'b0;
`else
        // PC wraps from 0xFFFF to 0x0000; unpopulated data passes through.
        redirect = 1'b1;
        target   = 16'hFFFF;
        step();
        redirect = 1'b0;
        step();
        check("wrap_pc", {16'h0000, pc}, 32'h0000_FFFF);
        check("wrap_rom_addr", {16'h0000, rom_addr}, 32'd0);
        expect_xfer(16'hFFFF, 32'hDEAD_FFFF);
        expect_xfer(16'h0000, W0);
        ready = 1'b1;
        step();
        step();
        check("wrap_next_pc", {16'h0000, pc}, 32'd1);
        check("no_fault", {31'd0, fault}, 32'd0);
        ready = 1'b0;
`endif

        // Asynchronous reset in the middle of a stall.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", {31'd0, valid}, 32'd0);
        check("async_pc", {16'h0000, pc}, 32'd0);
        check("async_instr", instr, 32'd0);
        check("async_rom_addr", {16'h0000, rom_addr}, 32'd0);
        step();
        rst_n = 1'b1;
        expect_xfer(16'h0000, W0);
        ready = 1'b1;
        step();
        check("post_rst_valid", {31'd0, valid}, 32'd1);
        check("post_rst_pc", {16'h0000, pc}, 32'd0);
        step();
        ready = 1'b0;

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit: the initiator side of the instruction ROM address/data interface. It owns the program counter, drives the ROM address, and captures the combinationally returned instruction into an output register. It hands fetched instructions to decode over a valid/ready handshake and accepts branch/jump redirects from execute. It sits between the instruction ROM and the decode stage.

## Interface

- CONTENT_SIZE, 16: PC / ROM address width (word address, one 32-bit instruction per address)
- INSTRUCT_SIZE, 32: instruction width
- TOTAL_ROM_SIZE, 256: number of populated ROM words; used only by the bounds check
- RESET_PC, 0: PC value loaded at reset

- i_clk  in  1  clock, all state updates on rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- o_rom_addr  out  CONTENT_SIZE  address to ROM; always equals current PC (combinational from PC register)
- i_rom_instr  in  INSTRUCT_SIZE  ROM data; valid in the same cycle as o_rom_addr
- o_instr  out  INSTRUCT_SIZE  fetched instruction (registered)
- o_pc  out  CONTENT_SIZE  address o_instr was fetched from (registered)
- o_valid  out  1  o_instr/o_pc hold a live instruction
- i_ready  in  1  decode accepts o_instr this cycle
- i_redirect  in  1  one-cycle pulse: discard in-flight fetch, continue at i_target
- i_target  in  CONTENT_SIZE  redirect address, sampled only when i_redirect=1
- o_fault  out  1  fetch attempted outside ROM (bounds check build only; tied 0 otherwise)

## Operation

- Reset (async assert): PC=RESET_PC, o_instr=0, o_pc=0, o_valid=0, o_fault=0, state=RUN.
- States: RUN, FAULT (FAULT exists only with the bounds check).
- advance = !o_valid || i_ready (output register empty or being drained).
- RUN, i_redirect=0, advance=1: o_instr<=i_rom_instr, o_pc<=PC, o_valid<=1, PC<=PC+1.
- RUN, i_redirect=0, advance=0: PC, o_instr, o_pc, o_valid hold (stall). ROM address stays stable.
- i_redirect=1, any state, highest priority: PC<=i_target, o_valid<=0, o_fault<=0, state<=RUN. A presented instruction with i_ready=1 in that cycle counts as consumed; with i_ready=0 it is dropped. No fetch is captured in the redirect cycle.
- PC increment is modulo 2^CONTENT_SIZE. 0xFFFF+1 wraps to 0x0000 with the default width.
- Simultaneous i_ready=1 and advance: back-to-back throughput of one instruction per cycle.
- Reset mid-stall or mid-redirect: all state returns to reset values immediately. The handshake is abandoned and no instruction is presented until the first post-reset fetch.

## Timing

- ROM path: o_rom_addr -> i_rom_instr is combinational. The fetch registers the result at the end of the same cycle. No ROM latency stage.
- Reset release to first o_valid=1: 1 rising edge. The first instruction has o_pc=RESET_PC.
- Redirect latency: i_redirect sampled at edge N. o_valid=0 after edge N. o_valid=1 with o_pc=i_target after edge N+1.
- Stall: while o_valid=1 and i_ready=0, o_instr and o_pc are stable every cycle.
- o_fault rises on the edge that would have captured an out-of-range fetch. o_valid is 0 from that edge on.

## Configuration

- IFETCH_BOUND_CHK_EN defined:
  - In RUN with advance=1 and PC >= TOTAL_ROM_SIZE, no capture occurs. The edge sets o_valid<=0, o_fault<=1, state<=FAULT.
  - FAULT holds PC and performs no fetches until i_redirect or reset.
  - Redirect clears the fault. A redirect to an out-of-range target faults again on its first fetch.
- IFETCH_BOUND_CHK_EN undefined:
  - No FAULT state; o_fault tied 0.
  - Fetch proceeds at any PC. Data returned for unpopulated addresses is whatever the ROM drives.

## Test plan

- Reset, RESET_PC=0, ROM words 0..2 = 0x08010000, 0x08220001, 0x04400800, i_ready=1 -> 3 consecutive cycles with o_valid=1, o_pc=0,1,2, and o_instr matching each word.
- i_ready held 0 for 4 cycles while o_valid=1 at o_pc=1 -> o_instr/o_pc constant, o_rom_addr=2 throughout. i_ready=1 -> next o_pc=2.
- Redirect with i_target=0x0040 while o_valid=1, i_ready=0 -> next cycle o_valid=0. Following cycle o_valid=1, o_pc=0x0040. Old instruction never accepted.
- Redirect in the same cycle as i_ready=1 -> presented instruction counted once, none between, then o_pc=target.
- With IFETCH_BOUND_CHK_EN, redirect to 0x00FE, TOTAL_ROM_SIZE=256 -> o_pc=0xFE, 0xFF delivered. Next edge o_fault=1, o_valid=0. Redirect to 0x0000 -> o_fault=0, o_pc=0 delivered.
- Assert i_rst_n=0 asynchronously mid-stall -> outputs hit reset values before the next clock edge. After release, first o_pc=RESET_PC.
